// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back data cache controller.
// Sits between the CPU byte interface and a 32-bit-block data memory.
// Serves read/write hits with no stall. On a miss it writes back a dirty
// victim, then fetches the new block using a level handshake on MEM_BUSYWAIT.
//
// Ports:
//   CLK, RESET        clock; synchronous active-high reset
//   READ, WRITE       CPU request, held until BUSYWAIT is low (both high = write)
//   ADDRESS[7:0]      tag[7:5], index[4:2], offset[1:0]
//   WRITEDATA[7:0]    CPU write byte
//   READDATA[7:0]     CPU read byte (combinational on hit, 0 otherwise)
//   BUSYWAIT          CPU stall
//   MEM_READ/WRITE    registered block fetch / write-back requests
//   MEM_ADDRESS[5:0]  block address {tag,index}
//   MEM_WRITEDATA     victim block, byte0 in [7:0]
//   MEM_READDATA      fetched block
//   MEM_BUSYWAIT      memory busy
//   HIT_COUNT, MISS_COUNT  saturating access counters (CACHE_STATS_EN only)
//
// Optional feature macro: CACHE_STATS_EN.
module dcache_ctrl #(
  parameter int unsigned NUM_SETS = 8
`ifdef CACHE_STATS_EN
  , parameter int unsigned STATS_W = 16
`endif
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
`ifdef CACHE_STATS_EN
  output logic [STATS_W-1:0] HIT_COUNT,
  output logic [STATS_W-1:0] MISS_COUNT,
`endif
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  localparam int unsigned IDX_W  = $clog2(NUM_SETS);
  localparam int unsigned BLK_AW = 6;
  localparam int unsigned TAG_W  = BLK_AW - IDX_W;
  localparam int unsigned BLK_W  = 32;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_e;

  state_e              state_q;
  logic [BLK_W-1:0]    data_q [NUM_SETS];
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [BLK_W-1:0]    fill_q;
  logic [BLK_W-1:0]    mem_wdata_q;
  logic [BLK_AW-1:0]   mem_addr_q;
  logic [BLK_AW-1:0]   miss_addr_q;
  logic                mem_read_q;
  logic                mem_write_q;

  logic [IDX_W-1:0] idx_c;
  logic [TAG_W-1:0] tag_c;
  logic [4:0]       boff_c;
  logic [IDX_W-1:0] fill_idx_c;
  logic [TAG_W-1:0] fill_tag_c;
  logic [BLK_W-1:0] line_c;
  logic             req_c;
  logic             hit_c;
  logic             wr_hit_c;

  // Address decode and hit detection against the indexed line
  assign idx_c      = ADDRESS[IDX_W+1:2];
  assign tag_c      = ADDRESS[7:IDX_W+2];
  assign boff_c     = {ADDRESS[1:0], 3'b000};
  assign fill_idx_c = miss_addr_q[IDX_W-1:0];
  assign fill_tag_c = miss_addr_q[BLK_AW-1:IDX_W];
  assign line_c     = data_q[idx_c];
  assign req_c      = READ | WRITE;
  assign hit_c      = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
  assign wr_hit_c   = (state_q == IDLE) && WRITE && hit_c && !RESET;

  // CPU-side outputs are combinational so a hit costs no stall cycle
  assign READDATA = hit_c ? line_c[boff_c +: 8] : 8'h00;
  assign BUSYWAIT = (state_q != IDLE) || (req_c && !hit_c);

  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;

  // Line data and tag storage (contents are don't-care until valid)
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (wr_hit_c) begin
        data_q[idx_c][boff_c +: 8] <= WRITEDATA;
      end else if (state_q == UPDATE) begin
        data_q[fill_idx_c] <= fill_q;
        tag_q[fill_idx_c]  <= fill_tag_c;
      end
    end
  end

  // Miss-handling FSM with registered memory requests
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      miss_addr_q <= '0;
      fill_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_c) begin
            if (hit_c) begin
              if (WRITE) dirty_q[idx_c] <= 1'b1;
            end else begin
              // Latch the miss block so the fill does not depend on ADDRESS later
              miss_addr_q <= ADDRESS[7:2];
              if (valid_q[idx_c] && dirty_q[idx_c]) begin
                state_q     <= WRITEBACK;
                mem_write_q <= 1'b1;
                mem_addr_q  <= {tag_q[idx_c], idx_c};
                mem_wdata_q <= line_c;
              end else begin
                state_q    <= FETCH;
                mem_read_q <= 1'b1;
                mem_addr_q <= ADDRESS[7:2];
              end
            end
          end
        end
        WRITEBACK: begin
          if (!MEM_BUSYWAIT) begin
            state_q     <= FETCH;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= miss_addr_q;
          end
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            state_q    <= UPDATE;
            mem_read_q <= 1'b0;
            fill_q     <= MEM_READDATA;
          end
        end
        UPDATE: begin
          valid_q[fill_idx_c] <= 1'b1;
          dirty_q[fill_idx_c] <= 1'b0;
          state_q             <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic post_fill_q;

  // Count each access once on first presentation; the replayed hit after a fill is skipped
  always_ff @(posedge CLK) begin
    if (RESET) begin
      post_fill_q <= 1'b0;
      HIT_COUNT   <= '0;
      MISS_COUNT  <= '0;
    end else begin
      post_fill_q <= (state_q == UPDATE);
      if ((state_q == IDLE) && req_c && !post_fill_q) begin
        if (hit_c) begin
          if (HIT_COUNT != '1) HIT_COUNT <= HIT_COUNT + STATS_W'(1);
        end else begin
          if (MISS_COUNT != '1) MISS_COUNT <= MISS_COUNT + STATS_W'(1);
        end
      end
    end
  end
`else
  // Statistics counters not built
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed plus random traffic against a line-level cache model
// and a block memory with programmable latency.
module tb_dcache_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ, MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;
  logic        MEM_BUSYWAIT;
`ifdef CACHE_STATS_EN
  logic [15:0] HIT_COUNT, MISS_COUNT;
`endif

  dcache_ctrl dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT),
`ifdef CACHE_STATS_EN
    .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT),
`endif
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Memory device: busy for 'lat' cycles of each request, then completes
  logic [31:0] dev_mem [64];
  int          lat = 0;
  int          done_cycles = 0;
  logic [1:0]  last_kind = 2'b00;
  logic [1:0]  kind;
  int          cur_done;

  assign kind = {MEM_WRITE, MEM_READ};
  always_comb begin
    cur_done = (kind == last_kind) ? done_cycles : 0;
    MEM_BUSYWAIT = (kind != 2'b00) && (cur_done < lat);
    MEM_READDATA = dev_mem[MEM_ADDRESS];
  end

  always @(posedge CLK) begin
    last_kind   <= kind;
    done_cycles <= (kind != 2'b00) ? cur_done + 1 : 0;
    if (MEM_WRITE && !MEM_BUSYWAIT) dev_mem[MEM_ADDRESS] <= MEM_WRITEDATA;
  end

  // Reference model: cache lines and backing memory as plain arrays
  logic [31:0] ref_mem [64];
  logic        m_valid [8];
  logic        m_dirty [8];
  logic [2:0]  m_tag   [8];
  logic [31:0] m_data  [8];
  int          m_hits, m_misses;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    #1;
    check_eq("rst_busywait", 32'(BUSYWAIT), 32'd0);
    check_eq("rst_memreq", 32'({MEM_WRITE, MEM_READ}), 32'd0);
    check_eq("rst_readdata", 32'(READDATA), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      READ = 1'b0; WRITE = 1'b0;
      #1;
      check_eq("idle_busywait", 32'(BUSYWAIT), 32'd0);
    end
  endtask

  // One CPU access: predict from the model, drive, observe the whole stall
  task automatic access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd);
    int         idx, off, stall, exp_stall;
    bit         hit, wb, saw_wb, saw_rd;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data, w;
    logic [7:0]  exp_rd;
    idx = int'(a[4:2]);
    off = int'(a[1:0]);
    hit = m_valid[idx] && (m_tag[idx] == a[7:5]);
    wb  = !hit && m_valid[idx] && m_dirty[idx];
    wb_addr = {m_tag[idx], a[4:2]};
    wb_data = m_data[idx];
    exp_stall = hit ? 0 : 2 + (lat + 1) * (wb ? 2 : 1);
    if (!hit) begin
      if (wb) ref_mem[wb_addr] = wb_data;
      m_data[idx]  = ref_mem[a[7:2]];
      m_tag[idx]   = a[7:5];
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_misses++;
    end else begin
      m_hits++;
    end
    w = m_data[idx];
    exp_rd = w[off*8 +: 8];
    if (wr) begin
      w[off*8 +: 8] = wd;
      m_data[idx]  = w;
      m_dirty[idx] = 1'b1;
    end

    @(negedge CLK);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
    #1;
    check_eq("busywait_req", 32'(BUSYWAIT), 32'(!hit));
    stall = 0; saw_wb = 0; saw_rd = 0;
    while (BUSYWAIT && stall < 200) begin
      check_eq("mem_excl", 32'(MEM_READ & MEM_WRITE), 32'd0);
      if (MEM_WRITE && !saw_wb) begin
        saw_wb = 1;
        check_eq("wb_addr", 32'(MEM_ADDRESS), 32'(wb_addr));
        check_eq("wb_data", MEM_WRITEDATA, wb_data);
      end
      if (MEM_READ && !saw_rd) begin
        saw_rd = 1;
        check_eq("fetch_addr", 32'(MEM_ADDRESS), 32'(a[7:2]));
      end
      stall++;
      @(negedge CLK);
      #1;
    end
    check_eq("stall_cycles", 32'(stall), 32'(exp_stall));
    check_eq("wb_seen", 32'(saw_wb), 32'(wb));
    check_eq("fetch_seen", 32'(saw_rd), 32'(!hit));
    check_eq("memreq_done", 32'({MEM_WRITE, MEM_READ}), 32'd0);
    if (rd && !wr) check_eq("readdata", 32'(READDATA), 32'(exp_rd));
  endtask

  initial begin
    int cyc;
    logic [7:0] ra;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      dev_mem[i] = ref_mem[i];
    end
    ref_mem[0] = 32'hDDCCBBAA; dev_mem[0] = 32'hDDCCBBAA;
    ref_mem[8] = 32'h44332211; dev_mem[8] = 32'h44332211;
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    model_reset();
    do_reset();

    // Cold miss, then hits within the filled block
    lat = 4;
    access(1, 0, 8'h00, 8'h00);
    access(1, 0, 8'h01, 8'h00);
    access(1, 0, 8'h02, 8'h00);
    access(1, 0, 8'h03, 8'h00);
    access(0, 1, 8'h00, 8'h05);
    // Conflict miss on a dirty line: write-back of 0xDDCCBB05 then fetch block 0x08
    access(1, 0, 8'h20, 8'h00);
    check_eq("wb_mem_block0", dev_mem[0], 32'hDDCCBB05);
    // READ and WRITE together act as a write
    access(1, 1, 8'h21, 8'h7E);
    access(1, 0, 8'h21, 8'h00);
    check_eq("rw_readback", 32'(READDATA), 32'h7E);
`ifdef CACHE_STATS_EN
    check_eq("hit_count_dir", 32'(HIT_COUNT), 32'(m_hits));
    check_eq("miss_count_dir", 32'(MISS_COUNT), 32'(m_misses));
`endif

    // Reset while a fetch is outstanding aborts it
    lat = 6;
    @(negedge CLK);
    READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h04;
    cyc = 0;
    #1;
    while (!MEM_READ && cyc < 10) begin
      @(negedge CLK); #1; cyc++;
    end
    check_eq("abort_fetch_started", 32'(MEM_READ), 32'd1);
    @(negedge CLK);
    RESET = 1'b1; READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    #1;
    check_eq("abort_memread", 32'(MEM_READ), 32'd0);
    check_eq("abort_busywait", 32'(BUSYWAIT), 32'd0);
    lat = 2;
    access(1, 0, 8'h00, 8'h00);

    // Stats sequence after reset: miss, hit, hit, miss
    do_reset();
`ifdef CACHE_STATS_EN
    check_eq("hit_count_rst", 32'(HIT_COUNT), 32'd0);
    check_eq("miss_count_rst", 32'(MISS_COUNT), 32'd0);
`endif
    access(1, 0, 8'h40, 8'h00);
    access(1, 0, 8'h41, 8'h00);
    access(1, 0, 8'h42, 8'h00);
    access(1, 0, 8'h60, 8'h00);
`ifdef CACHE_STATS_EN
    check_eq("hit_count_seq", 32'(HIT_COUNT), 32'd2);
    check_eq("miss_count_seq", 32'(MISS_COUNT), 32'd2);
`endif

    // Random traffic with random memory latency
    for (int n = 0; n < 300; n++) begin
      int op;
      op  = int'($urandom_range(0, 3));
      lat = int'($urandom_range(0, 4));
      ra  = 8'($urandom);
      case (op)
        0, 1:    access(1, 0, ra, 8'h00);
        2:       access(0, 1, ra, 8'($urandom));
        default: access(1, 1, ra, 8'($urandom));
      endcase
      if ($urandom_range(0, 7) == 0) idle(1);
    end
`ifdef CACHE_STATS_EN
    check_eq("hit_count_end", 32'(HIT_COUNT), 32'(m_hits));
    check_eq("miss_count_end", 32'(MISS_COUNT), 32'(m_misses));
`endif
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
